// File: rtl/otter_dcache_responder.sv
// OTTER data-port responder: direct-mapped, write-back, write-allocate cache, one word per line.
// Define DCACHE_PERF_EN to add the saturating hit_cnt/miss_cnt outputs.
module otter_dcache_responder #(
   parameter int INDEX_W = 4
) (
   input  logic        MEM_CLK,
   input  logic        MEM_RST,
   input  logic        MEM_RDEN2,
   input  logic        MEM_WE2,
   input  logic [31:0] MEM_ADDR2,
   input  logic [31:0] MEM_DIN2,
   input  logic [1:0]  MEM_SIZE,
   input  logic        MEM_SIGN,
   output logic [31:0] MEM_DOUT2,
   output logic        MEM_VALID2,
   output logic        ERR,
   output logic        bk_req,
   output logic        bk_we,
   output logic [29:0] bk_addr,
   output logic [31:0] bk_wdata,
   input  logic [31:0] bk_rdata,
`ifdef DCACHE_PERF_EN
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt,
`endif
   input  logic        bk_ack
);

   localparam int LINES = 1 << INDEX_W;
   localparam int TAG_W = 30 - INDEX_W;

   typedef enum logic [1:0] {IDLE, WB, REFILL} state_e;

   state_e              state_q, state_d;
   logic [LINES-1:0]    valid_q, valid_d;
   logic [LINES-1:0]    dirty_q, dirty_d;
   logic [TAG_W-1:0]    tag_q  [LINES];
   logic [31:0]         data_q [LINES];

   logic                active, isStore, isLoad;
   logic [INDEX_W-1:0]  idx;
   logic [TAG_W-1:0]    reqTag;
   logic                hit, idleHit, idleMiss;
   logic [31:0]         curWord, mergedWord, lineWdata;
   logic [7:0]          byteLane;
   logic [15:0]         halfLane;
   logic                lineWe, tagWe;

   assign active  = MEM_RDEN2 | MEM_WE2;
   assign isStore = MEM_WE2;
   assign isLoad  = MEM_RDEN2 & ~MEM_WE2;
   assign idx     = MEM_ADDR2[INDEX_W+1:2];
   assign reqTag  = MEM_ADDR2[31:INDEX_W+2];

   assign ERR = active && ((MEM_SIZE == 2'd3) ||
                           ((MEM_SIZE == 2'd1) && MEM_ADDR2[0]) ||
                           ((MEM_SIZE == 2'd2) && (MEM_ADDR2[1:0] != 2'b00)));

   assign curWord  = data_q[idx];
   assign hit      = valid_q[idx] && (tag_q[idx] == reqTag);
   assign idleHit  = (state_q == IDLE) && active && !ERR && hit;
   assign idleMiss = (state_q == IDLE) && active && !ERR && !hit;
   assign byteLane = curWord[{MEM_ADDR2[1:0], 3'b000} +: 8];
   assign halfLane = curWord[{MEM_ADDR2[1], 4'b0000} +: 16];

   always_ff @(posedge MEM_CLK or posedge MEM_RST) begin
      if (MEM_RST) begin
         state_q <= IDLE;
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (idleMiss) state_d = (valid_q[idx] && dirty_q[idx]) ? WB : REFILL;
         WB:      if (bk_ack) state_d = REFILL;
         REFILL:  if (bk_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mergedWord = curWord;
      case (MEM_SIZE)
         2'd0:    mergedWord[{MEM_ADDR2[1:0], 3'b000} +: 8] = MEM_DIN2[7:0];
         2'd1:    mergedWord[{MEM_ADDR2[1], 4'b0000} +: 16] = MEM_DIN2[15:0];
         default: mergedWord = MEM_DIN2;
      endcase
   end

   // Line updates: write-back clears dirty, refill installs a clean line, store hit merges and dirties.
   always_comb begin
      valid_d   = valid_q;
      dirty_d   = dirty_q;
      lineWe    = 1'b0;
      tagWe     = 1'b0;
      lineWdata = mergedWord;
      if ((state_q == WB) && bk_ack) begin
         dirty_d[idx] = 1'b0;
      end
      if ((state_q == REFILL) && bk_ack) begin
         valid_d[idx] = 1'b1;
         dirty_d[idx] = 1'b0;
         lineWe       = 1'b1;
         tagWe        = 1'b1;
         lineWdata    = bk_rdata;
      end
      if (idleHit && isStore) begin
         dirty_d[idx] = 1'b1;
         lineWe       = 1'b1;
      end
   end

   always_ff @(posedge MEM_CLK) begin
      if (lineWe) data_q[idx] <= lineWdata;
      if (tagWe)  tag_q[idx]  <= reqTag;
   end

   always_comb begin
      MEM_VALID2 = idleHit;
      MEM_DOUT2  = '0;
      bk_req     = (state_q != IDLE);
      bk_we      = (state_q == WB);
      bk_addr    = {reqTag, idx};
      bk_wdata   = curWord;
      if (state_q == WB) bk_addr = {tag_q[idx], idx};
      if (idleHit && isLoad) begin
         case (MEM_SIZE)
            2'd0:    MEM_DOUT2 = {{24{byteLane[7] & ~MEM_SIGN}}, byteLane};
            2'd1:    MEM_DOUT2 = {{16{halfLane[15] & ~MEM_SIGN}}, halfLane};
            default: MEM_DOUT2 = curWord;
         endcase
      end
   end

`ifdef DCACHE_PERF_EN
   logic [31:0] hitCnt_q, missCnt_q;

   always_ff @(posedge MEM_CLK or posedge MEM_RST) begin
      if (MEM_RST) begin
         hitCnt_q  <= '0;
         missCnt_q <= '0;
      end else begin
         if (idleHit && (hitCnt_q != 32'hFFFF_FFFF)) hitCnt_q <= hitCnt_q + 32'd1;
         if ((state_q == IDLE) && (state_d != IDLE) && (missCnt_q != 32'hFFFF_FFFF))
            missCnt_q <= missCnt_q + 32'd1;
      end
   end

   assign hit_cnt  = hitCnt_q;
   assign miss_cnt = missCnt_q;
`endif

endmodule
